tec8_beat_gen: RTL and testbench

Beat and phase timing generator that drives the hard-wired controller's timing inputs. It produces the W1/W2/W3 beat signals and the T1/T2/T3 phase pulses that the controller consumes. It also honours the SHORT, LONG and STOP requests that the controller drives back. It sits between the master clock / start button and the controller, forming the timing end of the controller's W/T3 ↔ SHORT/LONG/STOP interface.

---
 rtl/tec8_beat_gen.sv | 130 +++++++++++++
 tb/tb_tec8_beat_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tec8_beat_gen.sv
// tec8_beat_gen: beat (W1/W2/W3) and phase (T1/T2/T3) timing generator
// for the hard-wired controller. Starts on a synchronised QD press and
// honours SHORT / LONG / STOP at the T3 cycle of each beat.
// Optional feature macro: BEAT_SINGLE_STEP_EN adds the DP input. When DP=1
// at T3, the block advances the beat and then halts, just as it does for STOP.
//
// Handshake with the controller: there is no valid/ready pair. W is stable
// for the whole beat, and SHORT/LONG/STOP are sampled only on the clock
// edge that ends T3. The controller may therefore drive them combinationally
// from W and T.
module tec8_beat_gen (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        QD,
    input  logic        SHORT,
    input  logic        LONG,
    input  logic        STOP,
`ifdef BEAT_SINGLE_STEP_EN
    input  logic        DP,
`endif
    output logic [2:0]  W,
    output logic [2:0]  T,
    output logic        RUN,
    output logic [15:0] BEATS
);

    typedef enum logic [1:0] {
        PH_T1 = 2'd0,
        PH_T2 = 2'd1,
        PH_T3 = 2'd2
    } phase_t;

    phase_t      phase;
    phase_t      phase_nx;
    logic        run_nx;
    logic [2:0]  w_nx;
    logic [15:0] beats_nx;

    logic        qd_s1;
    logic        qd_s2;
    logic        qd_prev;
    logic [1:0]  sync_vld;
    logic        qd_rise;
    logic        halt_req;

`ifdef BEAT_SINGLE_STEP_EN
    assign halt_req = STOP | DP;
`else
    assign halt_req = STOP;
`endif

    // QD synchroniser and edge detector. qd_prev resets high and only starts
    // tracking once qd_s2 holds a real sample. As a result, a button held
    // down through CLR is not mistaken for a fresh press.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            qd_s1    <= 1'b0;
            qd_s2    <= 1'b0;
            qd_prev  <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            qd_s1    <= QD;
            qd_s2    <= qd_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1]) begin
                qd_prev <= qd_s2;
            end
        end
    end

    assign qd_rise = sync_vld[1] & qd_s2 & ~qd_prev;

    // State register: run flag, phase, beat and completed-beat counter.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            RUN   <= 1'b0;
            phase <= PH_T1;
            W     <= 3'b001;
            BEATS <= 16'd0;
        end else begin
            RUN   <= run_nx;
            phase <= phase_nx;
            W     <= w_nx;
            BEATS <= beats_nx;
        end
    end

    // Next state: step the phases while running, advance the beat at the
    // end of T3, and start on a QD press while halted.
    always_comb begin
        run_nx   = RUN;
        phase_nx = phase;
        w_nx     = W;
        beats_nx = BEATS;
        if (RUN) begin
            case (phase)
                PH_T1: phase_nx = PH_T2;
                PH_T2: phase_nx = PH_T3;
                default: begin
                    phase_nx = PH_T1;
                    beats_nx = BEATS + 16'd1;
                    case (W)
                        3'b001:  w_nx = SHORT ? 3'b001 : 3'b010;
                        3'b010:  w_nx = LONG  ? 3'b100 : 3'b001;
                        default: w_nx = 3'b001;
                    endcase
                    if (halt_req) begin
                        run_nx = 1'b0;
                    end
                end
            endcase
        end else if (qd_rise) begin
            run_nx   = 1'b1;
            phase_nx = PH_T1;
        end
    end

    // Phase pulse decode: one-hot while running, all zero when halted.
    always_comb begin
        T = 3'b000;
        if (RUN) begin
            case (phase)
                PH_T1:   T = 3'b001;
                PH_T2:   T = 3'b010;
                default: T = 3'b100;
            endcase
        end
    end

endmodule

// File: tb/tb_tec8_beat_gen.sv
// tb_tec8_beat_gen: randomized bench for tec8_beat_gen. It compares the DUT
// against a reference model that tracks the beat number, phase index and
// QD sample history as plain integers. Define BEAT_SINGLE_STEP_EN to also
// exercise DP.
module tb_tec8_beat_gen;

`ifdef BEAT_SINGLE_STEP_EN
    localparam bit SS_EN = 1'b1;
`else
    localparam bit SS_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        qd = 1'b0;
    logic        short_req = 1'b0;
    logic        long_req = 1'b0;
    logic        stop_req = 1'b0;
    logic        dp_req = 1'b0;
    logic [2:0]  w;
    logic [2:0]  t;
    logic        run;
    logic [15:0] beats;

    always #5 clk = ~clk;

    tec8_beat_gen dut (
        .CLK   (clk),
        .CLR   (clr),
        .QD    (qd),
        .SHORT (short_req),
        .LONG  (long_req),
        .STOP  (stop_req),
`ifdef BEAT_SINGLE_STEP_EN
        .DP    (dp_req),
`endif
        .W     (w),
        .T     (t),
        .RUN   (run),
        .BEATS (beats)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_beat is 1..3 and m_ph is 0..2 (T1..T3). qs holds the last QD
    // samples, seeded with a virtual '1' so that a level that is already
    // high at reset release is not counted as a press.
    int          m_run;
    int          m_ph;
    int          m_beat;
    logic [15:0] m_beats;
    bit          qs[$];
    bit          m_start;
    bit          m_halt;

    task automatic model_reset();
        m_run   = 0;
        m_ph    = 0;
        m_beat  = 1;
        m_beats = 16'd0;
        qs.delete();
        qs.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (clr) begin
            model_reset();
        end else begin
            m_start = 1'b0;
            if (qs.size() >= 3 && qs[qs.size()-2] == 1'b1 && qs[qs.size()-3] == 1'b0)
                m_start = 1'b1;
            qs.push_back(qd);
            if (qs.size() > 3) void'(qs.pop_front());
            m_halt = stop_req | (SS_EN & dp_req);
            if (m_run != 0) begin
                if (m_ph == 2) begin
                    case (m_beat)
                        1:       m_beat = short_req ? 1 : 2;
                        2:       m_beat = long_req ? 3 : 1;
                        default: m_beat = 1;
                    endcase
                    m_beats = m_beats + 16'd1;
                    if (m_halt) m_run = 0;
                    m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                end
            end else if (m_start) begin
                m_run = 1;
                m_ph  = 0;
            end
        end
    end

    logic [2:0] exp_w;
    logic [2:0] exp_t;
    always_comb begin
        exp_w = 3'b001 << (m_beat - 1);
        exp_t = (m_run != 0) ? (3'b001 << m_ph) : 3'b000;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("W", {29'd0, w}, {29'd0, exp_w});
            check_val("T", {29'd0, t}, {29'd0, exp_t});
            check_val("RUN", {31'd0, run}, (m_run != 0) ? 32'd1 : 32'd0);
            check_val("BEATS", {16'd0, beats}, {16'd0, m_beats});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int qd_hold;
    int pulses;
    logic [15:0] exp_beats;

    initial begin
        model_reset();
        tick(3);
        check_val("rst_w", {29'd0, w}, 32'h1);
        check_val("rst_t", {29'd0, t}, 32'h0);
        check_val("rst_run", {31'd0, run}, 32'h0);
        check_val("rst_beats", {16'd0, beats}, 32'h0);
        clr = 1'b0;
        chk_en = 1'b1;
        tick(4);

        // First press: check latency, then a normal W1,W2,W1,W2 run.
        qd = 1'b1;
        tick(1);
        check_val("lat_k", {31'd0, run}, 32'h0);
        tick(1);
        check_val("lat_k1", {31'd0, run}, 32'h0);
        tick(1);
        check_val("lat_t1", {29'd0, t}, 32'h1);
        qd = 1'b0;
        tick(12);
        check_val("four_beats", {16'd0, beats}, 32'h4);
        stop_req = 1'b1;
        tick(3);
        stop_req = 1'b0;
        tick(2);
        check_val("stopped", {31'd0, run}, 32'h0);

        // Random SHORT/LONG/STOP with QD levels held for 2..5 clocks.
        qd_hold = 3;
        for (int i = 0; i < 3000; i++) begin
            short_req = ($urandom_range(0, 3) == 0);
            long_req  = ($urandom_range(0, 2) == 0);
            stop_req  = ($urandom_range(0, 9) == 0);
            if (qd_hold == 0) begin
                qd = ~qd;
                qd_hold = $urandom_range(2, 5);
            end
            qd_hold--;
            tick(1);
        end

        // Reach W3/T2, then assert CLR asynchronously with QD held high.
        short_req = 1'b0;
        long_req  = 1'b1;
        stop_req  = 1'b0;
        qd = 1'b0;
        tick(3);
        qd = 1'b1;
        for (int c = 0; c < 60 && !(m_run != 0 && m_beat == 3 && m_ph == 1); c++) tick(1);
        check_val("pre_clr_w", {29'd0, w}, 32'h4);
        check_val("pre_clr_t", {29'd0, t}, 32'h2);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        check_val("aclr_w", {29'd0, w}, 32'h1);
        check_val("aclr_t", {29'd0, t}, 32'h0);
        check_val("aclr_run", {31'd0, run}, 32'h0);
        check_val("aclr_beats", {16'd0, beats}, 32'h0);
        tick(2);
        clr = 1'b0;
        tick(10);
        check_val("held_qd_no_start", {31'd0, run}, 32'h0);
        qd = 1'b0;
        tick(3);
        qd = 1'b1;
        tick(3);
        check_val("restart_run", {31'd0, run}, 32'h1);
        qd = 1'b0;
        long_req = 1'b0;
        stop_req = 1'b1;
        tick(12);
        stop_req = 1'b0;

`ifdef BEAT_SINGLE_STEP_EN
        // Single step: each press yields three T pulses and one beat.
        dp_req = 1'b1;
        tick(3);
        for (int p = 0; p < 4; p++) begin
            exp_beats = m_beats + 16'd1;
            pulses = 0;
            qd = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (c == 3) qd = 1'b0;
                tick(1);
                if (t != 3'b000) pulses++;
            end
            check_val("ss_pulses", pulses, 32'd3);
            check_val("ss_beats", {16'd0, beats}, {16'd0, exp_beats});
        end
        dp_req = 1'b0;
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
